// File: rtl/adder_pipe_pkg.sv
// Shared types and segment-sizing helper for the carry-segmented adder pipeline.
package adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_e;

  // Low segments are floor(width/stages) bits; the top segment absorbs the remainder.
  function automatic int seg_width(input int idx, input int width, input int stages);
    int seg;
    seg = width / stages;
    return (idx < stages - 1) ? seg : width - (stages - 1) * seg;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One carry-chain slot: adds a W-bit operand slice with the incoming carry and
// registers the partial sum, carry-out and valid bit when the slot is loaded.
module adder_segment #(
  parameter int W          = 1,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         valid_in,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         valid
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  // NOTE: state is written with <= so every flop samples pre-edge values,
  // independent of the order the simulator runs these blocks.
  always_ff @(posedge clk) begin
    if (reset)   valid <= 1'b0;
    else if (en) valid <= valid_in;
  end

  // NOTE: only the output slot clears its data on reset; interior data flops
  // are qualified by valid, so resetting them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (RESET_DATA && reset) {cout, sum} <= '0;
    else if (en)             {cout, sum} <= total;
  end

endmodule

// File: rtl/pipelined_adder_sub.sv
// Carry-segmented pipelined add/sub with valid/ready backpressure.
// Define ADDER_OVF_EN to add the registered signed-overflow output.
module pipelined_adder_sub
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 56,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SEG      = WIDTH / STAGES;
  localparam int LAST_SEG = seg_width(STAGES - 1, WIDTH, STAGES);

  logic [STAGES:0] vld, free, adv;
  op_mode_e        mode;
  logic [WIDTH-1:0] s0_a, s0_b;
  logic             s0_c, s0_v;

  assign mode = op_mode_e'(sub);

  // A slot is free to load when it is empty or its content moves on this cycle.
  always_comb begin
    // NOTE: defaults first so no path leaves a bit unassigned and infers a latch.
    adv          = '0;
    free         = '0;
    adv[STAGES]  = vld[STAGES] & out_ready;
    free[STAGES] = !vld[STAGES] | adv[STAGES];
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = vld[k] & free[k+1];
      free[k] = !vld[k] | adv[k];
    end
  end

  assign in_ready = free[0];
  assign vld[0]   = s0_v;

  always_ff @(posedge clk) begin
    if (reset)        s0_v <= 1'b0;
    else if (free[0]) s0_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (free[0]) begin
      s0_a <= a;
      s0_b <= (mode == OP_SUB) ? ~b : b;
      s0_c <= (mode == OP_SUB);
    end
  end

  for (genvar k = 1; k <= STAGES; k++) begin : g_seg
    localparam int LO     = (k - 1) * SEG;
    localparam int W      = (k == STAGES) ? LAST_SEG : SEG;
    localparam int REM_IN = WIDTH - LO;

    logic [REM_IN-1:0] a_in, b_in;
    logic              c_in, c_out;
    logic [W-1:0]      seg_sum;
    logic [LO+W-1:0]   done;

    adder_segment #(.W(W), .RESET_DATA(k == STAGES)) u_seg (
      .clk      (clk),
      .reset    (reset),
      .en       (free[k]),
      .valid_in (vld[k-1]),
      .cin      (c_in),
      .a        (a_in[W-1:0]),
      .b        (b_in[W-1:0]),
      .sum      (seg_sum),
      .cout     (c_out),
      .valid    (vld[k])
    );

    if (k == 1) begin : g_first
      assign a_in = s0_a;
      assign b_in = s0_b;
      assign c_in = s0_c;
      assign done = seg_sum;
    end else begin : g_next
      logic [LO-1:0] lo_q;
      assign a_in = g_seg[k-1].g_fwd.a_q;
      assign b_in = g_seg[k-1].g_fwd.b_q;
      assign c_in = g_seg[k-1].c_out;
      assign done = {seg_sum, lo_q};
      always_ff @(posedge clk) begin
        if (k == STAGES && reset) lo_q <= '0;
        else if (free[k])         lo_q <= g_seg[k-1].done;
      end
    end

    // Operand bits above this segment ride along for later slots.
    if (k < STAGES) begin : g_fwd
      logic [REM_IN-W-1:0] a_q, b_q;
      always_ff @(posedge clk) begin
        if (free[k]) begin
          a_q <= a_in[REM_IN-1:W];
          b_q <= b_in[REM_IN-1:W];
        end
      end
    end
  end

  assign out_valid = vld[STAGES];
  assign sum       = {g_seg[STAGES].c_out, g_seg[STAGES].done};

`ifdef ADDER_OVF_EN
  logic a_msb_q, b_msb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (free[STAGES]) begin
      a_msb_q <= g_seg[STAGES].a_in[LAST_SEG-1];
      b_msb_q <= g_seg[STAGES].b_in[LAST_SEG-1];
    end
  end

  assign overflow = (a_msb_q == b_msb_q) & (sum[WIDTH-1] != a_msb_q);
`endif

endmodule
